// File: rtl/hs_resp_pkg.sv
// Shared definitions for the handshake responder bank: channel state encoding,
// LFSR polynomial and the delay counter width.
package hs_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10,
    ST_HOLD = 2'b11
  } chan_state_e;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Wide enough for the largest delay, 255 + 255
  localparam int CNT_W = 9;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/hs_resp_chan.sv
// One handshake responder channel: accepts a request, counts down the delay
// it was handed at acceptance, then acknowledges (pulse or held 4-phase ack).
module hs_resp_chan
  import hs_resp_pkg::*;
#(
  parameter int FOUR_PHASE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic [CNT_W-1:0] dly_i,
  output logic             ack_o,
  output logic             busy_o,
  output logic             abort_o
);

  localparam bit FP = (FOUR_PHASE != 0);

  chan_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ack_q;
  logic             busy_q;
  logic             abort_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            cnt_q   <= dly_i;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A withdrawn request beats a counter that has just run out
          if (FP && !req_i) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b1;
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_ACK: begin
          if (FP) begin
            state_q <= ST_HOLD;
          end else begin
            // The ack cycle doubles as the idle slot, so a still-high request
            // is taken here, giving D+2 cycles between consecutive acks.
            ack_q <= 1'b0;
            if (req_i) begin
              cnt_q   <= dly_i;
              busy_q  <= 1'b1;
              state_q <= ST_WAIT;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (!FP || !req_i) begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_o   = ack_q;
  assign busy_o  = busy_q;
  assign abort_o = abort_q;

endmodule

// File: rtl/hs_responder_bank.sv
// Bank of independent handshake responders sharing one free-running LFSR that
// supplies each channel's pseudo-random delay slice.
module hs_responder_bank
  import hs_resp_pkg::*;
#(
  parameter int          NCH        = 4,
  parameter int          DLY_W      = 3,
  parameter int          MIN_DLY    = 0,
  parameter int          FOUR_PHASE = 0,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           fixed_en,
  input  logic [7:0]     fixed_dly,
  output logic [NCH-1:0] ack,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] abort
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Channel slices start at ch*DLY_W and wrap around the 16-bit register
  function automatic logic [DLY_W-1:0] rnd_slice(input logic [15:0] s, input int ch);
    logic [DLY_W-1:0] r;
    r = '0;
    for (int k = 0; k < DLY_W; k++) begin
      r[k] = s[4'((ch * DLY_W + k) % 16)];
    end
    return r;
  endfunction

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic [CNT_W-1:0] dly;

    always_comb begin
      if (fixed_en) begin
        dly = CNT_W'(fixed_dly);
      end else begin
        dly = CNT_W'(MIN_DLY) + CNT_W'(rnd_slice(lfsr_q, g));
      end
    end

    hs_resp_chan #(
      .FOUR_PHASE(FOUR_PHASE)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .req_i  (req[g]),
      .dly_i  (dly),
      .ack_o  (ack[g]),
      .busy_o (busy[g]),
      .abort_o(abort[g])
    );
  end

endmodule

// File: doc/hs_responder_bank.md
Name: hs_responder_bank

Overview:
- Bank of NCH independent handshake responders. Each channel answers a request with ack after a pseudo-random (or fixed) delay.
- Used as a testbench-side or in-fabric peer for exercising request/acknowledge races in the state-machine blocks.
- Generalises the single-channel start/done responder:
  - channel count, delay range and handshake protocol are all parametrised;
  - adds a 4-phase mode, abort detection and a deterministic delay override.

Parameters:
- NCH, 4: number of channels, 1..16.
- DLY_W, 3: width of the random delay slice, 1..8; random span = 2^DLY_W values.
- MIN_DLY, 0: constant added to every delay, 0..255.
- FOUR_PHASE, 0:
  - 0 = pulse mode: ack is a 1-cycle pulse; req is level-sampled only in IDLE.
  - 1 = 4-phase mode: ack is held until req falls.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req  in  NCH  per-channel request
- fixed_en  in  1  when 1, every accepted request uses fixed_dly instead of the LFSR value
- fixed_dly  in  8  deterministic delay used when fixed_en=1
- ack  out  NCH  per-channel acknowledge
- busy  out  NCH  channel is in WAIT (counting)
- abort  out  NCH  1-cycle pulse: request withdrawn before ack (4-phase mode only)

Behaviour:
- Reset: already decided as rst asynchronous, active-low; clock clk. While rst=0:
  - ack, busy and abort = 0;
  - all channels in IDLE, counters = 0;
  - LFSR = SEED.
  - Reset asserted mid-operation drops any pending ack immediately (asynchronously). No ack is issued later for that request.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances on every clk edge out of reset, regardless of channel activity.
- Delay value D at acceptance:
  - fixed_en=1: D = fixed_dly.
  - fixed_en=0: D = MIN_DLY + r_i, where r_i = DLY_W bits of the LFSR starting at bit index (i*DLY_W) mod 16, wrapping modulo 16.
  - Counter width = 9 bits, so no overflow at the maximum of 255+255.
- Per-channel FSM states: IDLE, WAIT, ACK, HOLD. Encoding goes in the package.
  - IDLE: if req[i]=1, load cnt=D and go to WAIT.
  - WAIT:
    - busy=1.
    - If cnt=0: go to ACK and register ack[i]=1.
    - Otherwise cnt decrements by 1.
  - ACK:
    - Pulse mode: ack[i]=0 on the next edge, go to IDLE. ack is high for exactly one cycle.
    - 4-phase mode: go to HOLD with ack held at 1.
  - HOLD (4-phase only): when req[i]=0, ack[i]=0 on that edge and go to IDLE.
  - Any illegal state: ack=0, go to IDLE.
- Latency: req[i] first sampled high at edge E0 → ack[i] high after edge E0+D+1.
  - Example: D=0 gives ack one cycle after acceptance.
- Pulse mode:
  - req changes during WAIT are ignored.
  - If req is still high when returning to IDLE, a new request is accepted on the following edge. Minimum spacing between acks = D+2 cycles.
- 4-phase mode, req falls during WAIT:
  - go to IDLE, abort[i]=1 for one cycle, no ack.
- 4-phase mode, req falls on the same edge that cnt reaches 0:
  - the abort wins; no ack.
- Channels are fully independent. Any number may accept on the same edge, each using its own LFSR slice from that same edge.
- fixed_en and fixed_dly are sampled only at acceptance. Changing them mid-WAIT has no effect.

Decomposition:
- Package hs_resp_pkg holds:
  - the state encoding (IDLE=2'b00, WAIT=2'b01, ACK=2'b10, HOLD=2'b11);
  - the LFSR tap constant 16'hB400;
  - the counter width constant CNT_W=9.
- Sub-module hs_resp_chan: one channel FSM plus counter, instantiated NCH times via generate.
- The top level owns the LFSR, the slice extraction and the fixed_en mux.

Test Plan:
1. Pulse mode, fixed_en=1, fixed_dly=3, req[0] held high from edge 10 → ack[0] high only after edge 14; busy[0] high for edges 11-14; next ack after edge 19.
2. 4-phase mode, fixed_dly=2, req[1] rises at edge 5 and falls at edge 20 → ack[1] rises after edge 8, stays high through edge 20, low after edge 20.
3. 4-phase abort: fixed_dly=10, req[2] high at edges 0-4 then low → abort[2] pulses once after edge 5; ack[2] never asserts.
4. Random mode, NCH=4, DLY_W=3, MIN_DLY=2, all req high for 2000 cycles → every observed D in 2..9; all eight values seen on each channel; channels not lock-stepped.
5. Reset mid-WAIT: fixed_dly=50, accept at edge 3, rst=0 at cycle 20 for 2 cycles → ack/busy drop immediately; LFSR=SEED; no ack after release until a new req.
6. Simultaneous events, 4-phase mode: req falls on the edge cnt=0 → abort=1, ack=0; req[0] and req[3] accepted on the same edge → independent counts as specified.
